expression_solver: RTL and testbench
====================================

Name: expression_solver

Overview:
Multi-cycle unsigned solver for the quadratic result = A*X*X + B*X + C. It uses a small FSM over a shared 16x16 multiplier and a 16-bit adder. Each computation is launched by a start level and reports result, zero, overflow and a completion flag. It sits as a standalone arithmetic peripheral driven by a controller that polls completed.

Parameters:
none (all widths fixed: X 8 bits, A/B/C/result 16 bits)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
start  input  1  level; sampled in IDLE to launch a computation
X  input  8  unsigned variable, zero-extended to 16 bits internally
A  input  16  unsigned quadratic coefficient
B  input  16  unsigned linear coefficient
C  input  16  unsigned constant term
result  output  16  registered low 16 bits of A*X*X + B*X + C
zero  output  1  registered; 1 when the last completed result == 0
overflow  output  1  registered; 1 if any intermediate step of the last computation lost bits
completed  output  1  registered; high while the FSM is in DONE

Behaviour:
- One clock; rst is asynchronous and active-high.
- rst asserted (at any time, including mid-computation): FSM goes to IDLE.
- rst asserted: result=0, zero=0, overflow=0, completed=0, and all internal registers are cleared.
- States are IDLE, SQ, MA, MB, ADD1, ADD2, DONE.
- IDLE: if start=1 at a rising edge, latch X, A, B and C into internal registers, clear the internal overflow accumulator, and go to SQ. Otherwise stay in IDLE.
- SQ: p <= X*X, then go to MA. This step cannot overflow (max 65025).
- MA: p <= low16(A*p); ovf |= (upper 16 bits of the product != 0); then go to MB.
- MB: q <= low16(B*X); ovf |= (upper bits != 0); then go to ADD1.
- ADD1: p <= p+q (mod 2^16); ovf |= carry-out; then go to ADD2.
- ADD2: result <= p+C (mod 2^16); overflow <= ovf | carry-out; zero <= (p+C mod 2^16 == 0); then go to DONE.
- DONE: completed=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency: with start high at rising edge 1, result, zero and overflow are valid and completed=1 after edge 6. completed drops after edge 7.
- Back-to-back: if start is held high, a new computation launches at edge 8. Completion repeats every 7 cycles.
- start is ignored in every state except IDLE.
- Input changes after the launch edge do not affect the computation in progress.
- result, zero and overflow hold their values until the next ADD2. They remain valid after completed falls.
- Arithmetic is unsigned throughout.
- Only one multiplier instance is used. Both multiplier operands are 16 bits; X is zero-extended.

Optional Feature:
ES_DONE_HOLD_EN
- Defined: completed stays high from entry into DONE until the next launch in IDLE (start=1 sampled) or rst. DONE still exits to IDLE after one cycle, and completed is held by a separate flag.
- Undefined: completed is a one-cycle pulse as described in Behaviour.

Test Plan:
- Nominal: rst pulse, then X=15, A=96, B=3, C=1, start=1. After edge 6: result=21646 (0x548E), zero=0, overflow=0, completed=1. After edge 7: completed=0.
- Zero result: X=0, A=0x1234, B=0x55, C=0 -> result=0, zero=1, overflow=0 at completion.
- Multiply overflow: X=255, A=2, B=0, C=0 -> result=0xFC02 (130050 mod 65536), overflow=1, zero=0.
- Add overflow with wrap to zero: X=1, A=0xFFFF, B=1, C=0 -> result=0, overflow=1, zero=1.
- Reset mid-operation: launch the nominal vector and assert rst after edge 3. All outputs are 0 immediately (asynchronously) and the FSM is in IDLE. Release rst with start=1: the full 6-edge latency is observed again and the result is 21646.
- Back-to-back and input stability: hold start=1 and change A to 0 after the launch edge. The first completion gives result=21646. The second completion (7 cycles later) gives result=46, with completed pulsing once per computation.

Source files
------------

// File: rtl/expression_solver.sv
// Multi-cycle unsigned quadratic solver: result = A*X*X + B*X + C over one shared 16x16 multiplier.
// Optional macro ES_DONE_HOLD_EN keeps completed high until the next launch instead of a one-cycle pulse.
module expression_solver (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  X,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] C,
  output logic [15:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        completed
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    MA   = 3'd2,
    MB   = 3'd3,
    ADD1 = 3'd4,
    ADD2 = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t      state, state_next;
  logic [15:0] x_r, a_r, b_r, c_r;
  logic [15:0] p, q;
  logic        ovf;
  logic [15:0] mul_a, mul_b;
  logic [15:0] add_a, add_b;
  logic [31:0] prod;
  logic [16:0] sum;

  // Operand steering for the single multiplier and single adder.
  always_comb begin
    state_next = state;
    mul_a      = x_r;
    mul_b      = x_r;
    add_a      = p;
    add_b      = q;
    case (state)
      IDLE: if (start) state_next = SQ;
      SQ:   state_next = MA;
      MA: begin
        mul_a      = a_r;
        mul_b      = p;
        state_next = MB;
      end
      MB: begin
        mul_a      = b_r;
        mul_b      = x_r;
        state_next = ADD1;
      end
      ADD1: state_next = ADD2;
      ADD2: begin
        add_b      = c_r;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign prod = {16'd0, mul_a} * {16'd0, mul_b};
  assign sum  = {1'b0, add_a} + {1'b0, add_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r      <= 16'd0;
      a_r      <= 16'd0;
      b_r      <= 16'd0;
      c_r      <= 16'd0;
      p        <= 16'd0;
      q        <= 16'd0;
      ovf      <= 1'b0;
      result   <= 16'd0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_r <= {8'd0, X};
          a_r <= A;
          b_r <= B;
          c_r <= C;
          ovf <= 1'b0;
        end
        SQ: p <= prod[15:0];
        MA: begin
          p   <= prod[15:0];
          ovf <= ovf | (|prod[31:16]);
        end
        MB: begin
          q   <= prod[15:0];
          ovf <= ovf | (|prod[31:16]);
        end
        ADD1: begin
          p   <= sum[15:0];
          ovf <= ovf | sum[16];
        end
        ADD2: begin
          result   <= sum[15:0];
          overflow <= ovf | sum[16];
          zero     <= (sum[15:0] == 16'd0);
        end
        default: ;
      endcase
    end
  end

`ifdef ES_DONE_HOLD_EN
  // Sticky flag: set on entry to DONE, cleared only by the next accepted launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         completed <= 1'b0;
    else if (state == ADD2)          completed <= 1'b1;
    else if (state == IDLE && start) completed <= 1'b0;
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) completed <= 1'b0;
    else     completed <= (state_next == DONE);
  end
`endif

endmodule

// File: tb/tb_expression_solver.sv
// Directed and randomized bench for expression_solver against an arithmetic reference model.
module tb_expression_solver;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  X;
  logic [15:0] A, B, C;
  logic [15:0] result;
  logic        zero, overflow, completed;

  int checks   = 0;
  int failures = 0;
  int after_launch_mode = 0;
  logic [17:0] exp_q[$];

  expression_solver dut (
    .clk(clk), .rst(rst), .start(start),
    .X(X), .A(A), .B(B), .C(C),
    .result(result), .zero(zero), .overflow(overflow), .completed(completed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: evaluate each step with plain integer arithmetic, noting any step exceeding 16 bits.
  function automatic logic [17:0] model(input int unsigned x, a, b, c);
    longint unsigned t1, t2, s, r;
    logic ovf;
    t1  = longint'(a) * longint'(x) * longint'(x);
    ovf = (t1 > 65535);
    t1  = t1 % 65536;
    t2  = longint'(b) * longint'(x);
    ovf = ovf | (t2 > 65535);
    s   = t1 + (t2 % 65536);
    ovf = ovf | (s > 65535);
    s   = s % 65536;
    r   = s + longint'(c);
    ovf = ovf | (r > 65535);
    r   = r % 65536;
    return {ovf, (r == 0), r[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] x, input logic [15:0] a, b, c);
    X = x; A = a; B = b; C = c;
    start = 1'b1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        if (after_launch_mode == 0) begin
          start = 1'b0;
          X = 8'($urandom); A = 16'($urandom); B = 16'($urandom); C = 16'($urandom);
        end else begin
          A = 16'd0;
        end
      end
      if (completed === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [17:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3ffff;
    check({tag, "_result"},   32'(result),   32'(e[15:0]));
    check({tag, "_zero"},     32'(zero),     32'(e[16]));
    check({tag, "_overflow"}, 32'(overflow), 32'(e[17]));
  endtask

  task automatic finish_vec(input string tag);
    int n;
    wait_done(n);
    check({tag, "_latency"}, 32'(n), 32'd6);
    check_outputs(tag);
    @(posedge clk); #1;
    check({tag, "_completed_drop"}, 32'(completed), 32'd0);
  endtask

  task automatic run_vec(input string tag, input logic [7:0] x, input logic [15:0] a, b, c);
    @(negedge clk);
    after_launch_mode = 0;
    exp_q.push_back(model(x, a, b, c));
    drive(x, a, b, c);
    finish_vec(tag);
  endtask

  initial begin
    int n;
    logic [7:0]  rx;
    logic [15:0] ra, rb, rc;
    rst = 1'b1; start = 1'b0; X = '0; A = '0; B = '0; C = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result",    32'(result),    32'd0);
    check("reset_zero",      32'(zero),      32'd0);
    check("reset_overflow",  32'(overflow),  32'd0);
    check("reset_completed", 32'(completed), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_vec("nominal", 8'd15, 16'd96, 16'd3, 16'd1);
    check("nominal_const", 32'(result), 32'd21646);
    run_vec("zero_res", 8'd0, 16'h1234, 16'h0055, 16'd0);
    run_vec("add_wrap", 8'd1, 16'hFFFF, 16'd1, 16'd0);
    check("add_wrap_zero_const", 32'(zero), 32'd1);

    for (int i = 0; i < 20; i++) begin
      rx = 8'($urandom_range(0, 255));
      ra = (i % 2 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      rb = (i % 3 == 0) ? 16'($urandom_range(0, 200)) : 16'($urandom);
      rc = 16'($urandom);
      run_vec("random", rx, ra, rb, rc);
    end

    run_vec("mul_ovf", 8'd255, 16'd2, 16'd0, 16'd0);
    check("mul_ovf_const", 32'(result), 32'hFC02);

    // Abort a computation after edge 3; outputs must clear without waiting for a clock edge.
    @(negedge clk);
    drive(8'd15, 16'd96, 16'd3, 16'd1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_result",    32'(result),    32'd0);
    check("midrst_zero",      32'(zero),      32'd0);
    check("midrst_overflow",  32'(overflow),  32'd0);
    check("midrst_completed", 32'(completed), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    after_launch_mode = 0;
    exp_q.push_back(model(15, 96, 3, 1));
    drive(8'd15, 16'd96, 16'd3, 16'd1);
    finish_vec("after_rst");

    // Back-to-back with start held; A changes after launch and only affects the second run.
    @(negedge clk);
    after_launch_mode = 1;
    exp_q.push_back(model(15, 96, 3, 1));
    exp_q.push_back(model(15, 0, 3, 1));
    drive(8'd15, 16'd96, 16'd3, 16'd1);
    wait_done(n);
    check("b2b1_latency", 32'(n), 32'd6);
    check_outputs("b2b1");
    @(posedge clk); #1;
    check("b2b1_completed_drop", 32'(completed), 32'd0);
    wait_done(n);
    check("b2b_period", 32'(n + 1), 32'd7);
    check_outputs("b2b2");
    check("b2b2_const", 32'(result), 32'd46);
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b2_completed_drop", 32'(completed), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_relaunch", 32'(completed), 32'd0);
    check("result_held", 32'(result), 32'd46);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
